// File: rtl/tx_block_pkg.sv
// Shared definitions for the tx_block UART transmitter: FSM state encoding,
// STATUS register codes, CONTROL bit positions and the parity helper.
package tx_block_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA_BITS = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4
    } tx_state_e;

    localparam logic [7:0] STATUS_BUSY = 8'hFF;
    localparam logic [7:0] STATUS_IDLE = 8'h00;
    localparam int         CTRL_TX_BIT = 0;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tx_block_if.sv
// Host-side register bus of the UART transmitter.
// master = host/CPU side, slave = tx_block.
interface tx_block_if;
    logic [7:0] CONTROL;
    logic [7:0] DATA;
    logic [7:0] STATUS;
    logic       LINE_OUT;

    modport master (output CONTROL, output DATA, input STATUS, input LINE_OUT);
    modport slave  (input CONTROL, input DATA, output STATUS, output LINE_OUT);
endinterface

// File: rtl/tx_baud_gen.sv
// Bit-period timer: a down-counter reloaded with CLKS_PER_BIT-1 on each frame
// start and at every bit boundary. bit_tick_o is high for the last cycle of
// each bit period while the transmitter is running.
module tx_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic restart_i,
    input  logic run_i,
    output logic bit_tick_o
);
    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next-count selection: restart wins, otherwise count down and wrap on tick.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = RELOAD;
        end else if (run_i) begin
            if (cnt_q == 16'd0) begin
                cnt_d = RELOAD;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = run_i && !restart_i && (cnt_q == 16'd0);

endmodule

// File: rtl/tx_block.sv
// Memory-mapped UART transmitter (8N1, or 8E1 when TX_PARITY_EN is defined).
// Optional feature macro: TX_PARITY_EN inserts an even-parity bit before STOP.
// FSM, shift register and registered outputs live here; bit timing comes
// from tx_baud_gen.
module tx_block
    import tx_block_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    tx_block_if.slave   bus
);
    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] status_q, status_d;
    logic       line_q, line_d;
    logic       start_s;
    logic       run_s;
    logic       bit_tick_s;
    logic       unused_ctrl_s;
`ifdef TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    assign run_s         = (state_q != IDLE);
    assign unused_ctrl_s = ^bus.CONTROL[7:1];

    tx_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .restart_i  (start_s),
        .run_i      (run_s),
        .bit_tick_o (bit_tick_s)
    );

    // Frame sequencing: next state, shift register and next output values.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        status_d  = status_q;
        line_d    = line_q;
        start_s   = 1'b0;
`ifdef TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.CONTROL[CTRL_TX_BIT]) begin
                    state_d   = START;
                    shift_d   = bus.DATA;
                    bit_idx_d = 3'd0;
                    status_d  = STATUS_BUSY;
                    line_d    = 1'b0;
                    start_s   = 1'b1;
`ifdef TX_PARITY_EN
                    parity_d  = even_parity(bus.DATA);
`endif
                end else begin
                    status_d = STATUS_IDLE;
                    line_d   = 1'b1;
                end
            end
            START: begin
                if (bit_tick_s) begin
                    state_d = DATA_BITS;
                    line_d  = shift_q[0];
                end else begin
                    state_d = START;
                end
            end
            DATA_BITS: begin
                if (bit_tick_s) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_d = PARITY;
                        line_d  = parity_q;
`else
                        state_d = STOP;
                        line_d  = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        line_d    = shift_q[1];
                    end
                end else begin
                    state_d = DATA_BITS;
                end
            end
            PARITY: begin
                if (bit_tick_s) begin
                    state_d = STOP;
                    line_d  = 1'b1;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (bit_tick_s) begin
                    state_d  = IDLE;
                    status_d = STATUS_IDLE;
                    line_d   = 1'b1;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d  = IDLE;
                status_d = STATUS_IDLE;
                line_d   = 1'b1;
            end
        endcase
    end

    // State and output registers; reset forces an idle line immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            status_q  <= STATUS_IDLE;
            line_q    <= 1'b1;
`ifdef TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            status_q  <= status_d;
            line_q    <= line_d;
`ifdef TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.STATUS   = status_q;
    assign bus.LINE_OUT = line_q;

endmodule

// File: tb/tb_tx_block.sv
// Self-checking bench for tx_block. Expected line levels come from a frame
// model built as a list of bit values (start, data LSB first, optional
// parity, stop), each held for CPB cycles.
module tb_tx_block;
    localparam int CPB = 16;
`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;

    tx_block_if bus ();

    tx_block #(.CLKS_PER_BIT(CPB)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one request and check every cycle of the resulting frame.
    // abort_at >= 0 asserts reset during cycle abort_at of the frame.
    task automatic run_frame(input logic [7:0] d, input bit hold, input bit glitch, input int abort_at);
        logic exp_bits[$];
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(((d >> i) & 8'd1) != 8'd0);
`ifdef TX_PARITY_EN
        begin
            int ones = 0;
            for (int i = 0; i < 8; i++) ones += int'((d >> i) & 8'd1);
            exp_bits.push_back((ones % 2) == 1);
        end
`endif
        exp_bits.push_back(1'b1);
        bus.DATA    = d;
        bus.CONTROL = hold ? 8'h01 : 8'hFF;
        for (int n = 0; n < FRAME_BITS * CPB; n++) begin
            @(negedge CLK);
            check8("status_busy", bus.STATUS, 8'hFF);
            check8("line_bit", {7'd0, bus.LINE_OUT}, {7'd0, exp_bits[n / CPB]});
            if (n == 0 && !hold) bus.CONTROL = 8'h00;
            if (glitch && n == 4 * CPB + 5) bus.DATA = 8'hFF;
            if (n == abort_at) begin
                #1 RST_N = 1'b0;
                #1;
                check8("abort_line", {7'd0, bus.LINE_OUT}, 8'h01);
                check8("abort_status", bus.STATUS, 8'h00);
                return;
            end
        end
        @(negedge CLK);
        check8("frame_end_status", bus.STATUS, 8'h00);
        check8("frame_end_line", {7'd0, bus.LINE_OUT}, 8'h01);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check8("idle_status", bus.STATUS, 8'h00);
            check8("idle_line", {7'd0, bus.LINE_OUT}, 8'h01);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        RST_N       = 1'b0;
        bus.CONTROL = 8'h00;
        bus.DATA    = 8'h00;

        // Reset held: outputs stay idle regardless of inputs.
        for (int i = 0; i < 8; i++) begin
            bus.CONTROL = 8'($urandom);
            bus.DATA    = 8'($urandom);
            @(negedge CLK);
            check8("reset_status", bus.STATUS, 8'h00);
            check8("reset_line", {7'd0, bus.LINE_OUT}, 8'h01);
        end
        bus.CONTROL = 8'h00;
        @(negedge CLK);
        RST_N = 1'b1;
        idle_cycles(12);

        // Basic frame, host clears CONTROL on busy; no second frame.
        run_frame(8'h4E, 1'b0, 1'b0, -1);
        idle_cycles(20);

        // DATA changed during bit 3 must not affect the frame.
        run_frame(8'h4E, 1'b0, 1'b1, -1);
        idle_cycles(5);

        // Back-to-back with CONTROL held: one idle cycle between frames.
        run_frame(8'h55, 1'b1, 1'b0, -1);
        run_frame(8'h55, 1'b1, 1'b0, -1);
        run_frame(8'h55, 1'b0, 1'b0, -1);
        idle_cycles(5);

        // Parity corner values and an upper-CONTROL-bits-only write.
        run_frame(8'h07, 1'b0, 1'b0, -1);
        idle_cycles(3);
        bus.CONTROL = 8'hFE;
        idle_cycles(10);
        bus.CONTROL = 8'h00;

        // Reset during bit 5 aborts at once; then a full frame follows.
        run_frame(8'hA3, 1'b0, 1'b0, 6 * CPB + 3);
        for (int i = 0; i < 4; i++) begin
            bus.CONTROL = 8'($urandom);
            @(negedge CLK);
            check8("abort_hold_status", bus.STATUS, 8'h00);
            check8("abort_hold_line", {7'd0, bus.LINE_OUT}, 8'h01);
        end
        bus.CONTROL = 8'h00;
        RST_N = 1'b1;
        idle_cycles(2);
        run_frame(8'hC9, 1'b0, 1'b0, -1);
        idle_cycles(2);

        // Randomized frames with random gaps.
        for (int k = 0; k < 6; k++) begin
            run_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, -1);
            bus.CONTROL = 8'h00;
            idle_cycles(int'($urandom_range(1, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
